fir_engine: RTL and testbench
=============================

# fir_engine

Datapath/control stage directly downstream of the APB register block in the FIR accelerator. It consumes `Start`, `Ile_wsp` and `Ile_probek`, and returns `pracuje` and `DONE` to the same block. For each output sample it reads coefficients and input samples from two synchronous-read RAMs, multiply-accumulates them, and writes one rounded, saturated result per sample to an output RAM. Runs entirely in the `clk_b` domain.

## Interface
- DATA_W, 16: sample, coefficient and result width (signed, Q15)
- ACC_W, 38: accumulator width (32-bit product + 6 guard bits for up to 63 taps)
- clk_b  in  1  processing clock, single clock domain
- rst  in  1  synchronous, active-high reset
- Start  in  1  level from the APB block; a rising edge starts a run
- Ile_wsp  in  6  tap count W (0..63)
- Ile_probek  in  14  sample count N (0..16383)
- pracuje  out  1  high while a run is in progress
- DONE  out  1  high from run completion until the next accepted start or reset
- coef_addr  out  6  coefficient RAM read address
- coef_data  in  16  coefficient RAM data, valid 1 cycle after the address
- x_addr  out  14  sample RAM read address
- x_data  in  16  sample RAM data, valid 1 cycle after the address
- y_addr  out  14  result RAM write address
- y_data  out  16  result RAM write data
- y_we  out  1  result RAM write enable, one cycle per result

## Operation
- The block has one clock and a synchronous, active-high reset: `clk_b`, `rst`.
- Reset state: all outputs 0, FSM in IDLE, start-edge register 0.
- Start detection: `start_q` registers `Start` every cycle. A start is accepted when `Start & ~start_q` and the FSM is in IDLE. Edges seen in any other state are ignored.
- States:
  - IDLE: on an accepted start, go to LOAD.
  - LOAD: latch W and N; set n=0, k=0 and acc=0; clear DONE; set `pracuje`=1. If W==0 or N==0, go to FIN. Otherwise go to MAC.
  - MAC: drive `coef_addr`=k and `x_addr`=n−k. Add the product of the previous cycle's issued pair to acc. k runs from 0 to kmax = min(W−1, n), one address pair per cycle. After kmax, go to DRAIN.
  - DRAIN: add the last product to acc. Go to WRITE.
  - WRITE: assert `y_we` with `y_addr`=n and `y_data`=sat16((acc + 2^14) >>> 15). Clear acc and set k=0. If n==N−1, go to FIN. Otherwise set n=n+1 and go to MAC.
  - FIN: set `pracuje`=0 and DONE=1. Go to IDLE.
- Terms with n−k<0 are never issued, so they contribute zero and the filter starts from zero initial state.
- Arithmetic:
  - Multiplication is signed 16×16 to 32 bits, sign-extended to ACC_W.
  - There is no overflow inside acc.
  - Saturation clamps the result to [−32768, 32767].
- Changes to `Ile_wsp` or `Ile_probek` during a run have no effect until the next LOAD.
- A reset mid-run returns the block to the reset state immediately. No further `y_we` is issued.

## Timing
- An accepted start at cycle c puts the FSM in LOAD at c+1 and in the first MAC at c+2.
- Output n costs m_n + 2 cycles, where m_n = min(W, n+1).
- DONE rises, and `pracuje` falls, at cycle c + 2 + Σ(m_n + 2) + 1 (the cycle after the FIN cycle).
- The `y_we` for output n falls in the last cycle of that output's slot and lasts exactly 1 cycle.
- Zero-parameter run: DONE rises at c+3, with no `y_we`.
- `pracuje` is high from c+2 through the FIN cycle.

## Structure
- Package `fir_pkg`:
  - DATA_W and ACC_W constants
  - state enum typedef (IDLE, LOAD, MAC, DRAIN, WRITE, FIN)
  - function `sat_round_q15` (ACC_W → 16)
- Sub-module `fir_mac`: registered signed multiply-accumulate with `clr` and `en` inputs, plus the round/saturate output stage.
- `fir_engine` holds the FSM, the n/k counters, the address generation and the start edge detect.

## Test plan
- Reset mid-run: assert `rst` during MAC → next cycle all outputs 0, FSM in IDLE, no `y_we` afterwards.
- Single-tap gain: W=1, coef[0]=0x4000, N=4, x=[100, 200, −300, 32767] → y=[50, 100, −150, 16384]; DONE at c+15.
- Three-tap average: W=3, coefs=0x4000 ×3, N=4, x=[1000, 2000, 3000, 4000] → y=[500, 1500, 3000, 4500]; DONE at c+20.
- Saturation: W=2, coefs=[0x8000, 0x8000], N=2, x=[0x8000, 0x8000] → y0=32767, y1=32767.
- Zero parameters: N=0 (then W=0 with N=5) → DONE at c+3, zero `y_we` pulses, `pracuje` high for exactly 1 cycle.
- Start while busy: toggle `Start` 0→1 during MAC → ignored, outputs identical to the single run. A new edge after DONE → DONE clears at LOAD and the run repeats.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and the Q15 round/saturate helper for the
// FIR engine.
//   DATA_W        : sample / coefficient / result width (signed Q15)
//   ACC_W         : accumulator width (32-bit product + 6 guard bits)
//   W_W, N_W      : tap-count and sample-count field widths
//   fir_state_e   : engine FSM states
//   sat_round_q15 : ACC_W accumulator -> rounded, saturated DATA_W result
package fir_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 38;
    localparam int unsigned W_W    = 6;
    localparam int unsigned N_W    = 14;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StDrain,
        StWrite,
        StFin
    } fir_state_e;

    // Round half up at bit 15, arithmetic shift back to Q15, then clamp.
    function automatic logic signed [DATA_W-1:0] sat_round_q15(
        input logic signed [ACC_W-1:0] acc
    );
        localparam logic signed [ACC_W-1:0] RoundHalf = ACC_W'(16384);
        localparam logic signed [ACC_W-1:0] SatMax    = ACC_W'(32767);
        localparam logic signed [ACC_W-1:0] SatMin    = -ACC_W'(32768);
        logic signed [ACC_W-1:0] rounded;
        logic signed [ACC_W-1:0] shifted;
        logic signed [DATA_W-1:0] res;
        rounded = acc + RoundHalf;
        shifted = rounded >>> 15;
        if (shifted > SatMax) begin
            res = 16'sh7FFF;
        end else if (shifted < SatMin) begin
            res = 16'sh8000;
        end else begin
            res = shifted[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with rounded/saturated Q15 output.
//   clk_b  : processing clock
//   rst    : synchronous active-high reset (clears the accumulator)
//   clr    : clear accumulator this cycle (has priority over en)
//   en     : add a*b to the accumulator this cycle
//   a, b   : signed DATA_W operands
//   result : sat_round_q15 of the current accumulator value
module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk_b,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    always_comb begin
        prod     = a * b;
        prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = sat_round_q15(acc_q);

endmodule

// File: rtl/fir_engine.sv
// FIR engine: start edge detect, run FSM, n/k counters and RAM address
// generation around a single MAC unit. One rounded/saturated result is
// written per output sample.
//   clk_b, rst            : clock, synchronous active-high reset
//   Start                 : level; rising edge in IDLE starts a run
//   Ile_wsp, Ile_probek   : tap count W, sample count N (latched in LOAD)
//   pracuje, DONE         : run in progress / run complete status
//   coef_addr, coef_data  : coefficient RAM read port (1-cycle latency)
//   x_addr, x_data        : sample RAM read port (1-cycle latency)
//   y_addr, y_data, y_we  : result RAM write port
module fir_engine
    import fir_pkg::*;
(
    input  logic              clk_b,
    input  logic              rst,
    input  logic              Start,
    input  logic [W_W-1:0]    Ile_wsp,
    input  logic [N_W-1:0]    Ile_probek,
    output logic              pracuje,
    output logic              DONE,
    output logic [W_W-1:0]    coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic [N_W-1:0]    x_addr,
    input  logic [DATA_W-1:0] x_data,
    output logic [N_W-1:0]    y_addr,
    output logic [DATA_W-1:0] y_data,
    output logic              y_we
);

    fir_state_e       state_q;
    logic             start_q;
    logic [W_W-1:0]   w_q;
    logic [N_W-1:0]   n_tot_q;
    logic [N_W-1:0]   n_q;
    logic [W_W-1:0]   k_q;
    logic             pracuje_q;
    logic             done_q;

    logic             start_acc;
    logic             mac_last;
    logic             mac_clr;
    logic             mac_en;
    logic [N_W-1:0]   k_ext;
    logic signed [DATA_W-1:0] mac_result;

    assign k_ext     = {{(N_W - W_W){1'b0}}, k_q};
    assign start_acc = Start & ~start_q & (state_q == StIdle);
    // k has reached min(W-1, n): whichever bound k hits first is the minimum.
    assign mac_last  = (k_q == w_q - 1'b1) || (k_ext == n_q);

    always_ff @(posedge clk_b) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            w_q       <= '0;
            n_tot_q   <= '0;
            n_q       <= '0;
            k_q       <= '0;
            pracuje_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q <= Start;
            unique case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    w_q       <= Ile_wsp;
                    n_tot_q   <= Ile_probek;
                    n_q       <= '0;
                    k_q       <= '0;
                    done_q    <= 1'b0;
                    pracuje_q <= 1'b1;
                    if (Ile_wsp == '0 || Ile_probek == '0) begin
                        state_q <= StFin;
                    end else begin
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    if (mac_last) begin
                        state_q <= StDrain;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDrain: begin
                    state_q <= StWrite;
                end
                StWrite: begin
                    k_q <= '0;
                    if (n_q == n_tot_q - 1'b1) begin
                        state_q <= StFin;
                    end else begin
                        n_q     <= n_q + 1'b1;
                        state_q <= StMac;
                    end
                end
                StFin: begin
                    pracuje_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // RAM data arrives one cycle after its address, so the first MAC cycle of
    // each output has nothing to add yet and DRAIN adds the final pair.
    assign mac_clr = (state_q == StLoad) || (state_q == StWrite);
    assign mac_en  = ((state_q == StMac) && (k_q != '0)) || (state_q == StDrain);

    fir_mac u_mac (
        .clk_b  (clk_b),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .a      ($signed(coef_data)),
        .b      ($signed(x_data)),
        .result (mac_result)
    );

    assign coef_addr = k_q;
    assign x_addr    = n_q - k_ext;
    assign y_addr    = n_q;
    assign y_data    = mac_result;
    assign y_we      = (state_q == StWrite);
    assign pracuje   = pracuje_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_fir_engine.sv
// Directed self-checking bench for fir_engine with behavioural
// synchronous-read RAMs and hand-computed expected results.
module tb_fir_engine;

    logic        clk_b = 1'b0;
    logic        rst;
    logic        Start;
    logic [5:0]  Ile_wsp;
    logic [13:0] Ile_probek;
    logic        pracuje;
    logic        DONE;
    logic [5:0]  coef_addr;
    logic [15:0] coef_data;
    logic [13:0] x_addr;
    logic [15:0] x_data;
    logic [13:0] y_addr;
    logic [15:0] y_data;
    logic        y_we;

    fir_engine dut (
        .clk_b      (clk_b),
        .rst        (rst),
        .Start      (Start),
        .Ile_wsp    (Ile_wsp),
        .Ile_probek (Ile_probek),
        .pracuje    (pracuje),
        .DONE       (DONE),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .x_addr     (x_addr),
        .x_data     (x_data),
        .y_addr     (y_addr),
        .y_data     (y_data),
        .y_we       (y_we)
    );

    always #5 clk_b = ~clk_b;

    logic [15:0] coef_mem [0:63];
    logic [15:0] x_mem    [0:16383];

    always @(posedge clk_b) begin
        coef_data <= coef_mem[coef_addr];
        x_data    <= x_mem[x_addr];
    end

    logic [13:0] wr_addr [$];
    logic [15:0] wr_data [$];
    int          busy_cyc;

    always @(negedge clk_b) begin
        if (y_we) begin
            wr_addr.push_back(y_addr);
            wr_data.push_back(y_data);
        end
        if (pracuje) busy_cyc++;
    end

    int total = 0;
    int bad   = 0;
    int exp_y [4];

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts a run and counts clock edges until DONE rises. With poke set,
    // Start is toggled while busy and the parameters are changed mid-run.
    task automatic run_fir(input int w, input int n, input bit poke, output int edges);
        bit prev;
        bit hit;
        @(negedge clk_b);
        Ile_wsp    = 6'(w);
        Ile_probek = 14'(n);
        wr_addr.delete();
        wr_data.delete();
        busy_cyc = 0;
        prev  = DONE;
        hit   = 1'b0;
        edges = 0;
        Start = 1'b1;
        while (!hit && edges < 400) begin
            @(posedge clk_b);
            edges++;
            @(negedge clk_b);
            if (edges == 2) check_eq("done_clr_at_load", int'(DONE), 0);
            if (poke && edges == 2) Start = 1'b0;
            if (poke && edges == 4) begin
                Start      = 1'b1;
                Ile_wsp    = 6'd5;
                Ile_probek = 14'd9;
            end
            if (DONE && !prev) hit = 1'b1;
            prev = DONE;
        end
        check_eq("done_seen", int'(hit), 1);
        Start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int edges, input int exp_edges,
                             input int exp_busy, input int n_exp);
        check_eq({tag, "_done_cyc"}, edges, exp_edges);
        check_eq({tag, "_busy_cyc"}, busy_cyc, exp_busy);
        check_eq({tag, "_n_wr"}, wr_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
            check_eq({tag, "_addr"}, int'(wr_addr[i]), i);
            check_eq({tag, "_y"}, int'($signed(wr_data[i])), exp_y[i]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_pracuje"}, int'(pracuje), 0);
        check_eq({tag, "_done"}, int'(DONE), 0);
        check_eq({tag, "_y_we"}, int'(y_we), 0);
        check_eq({tag, "_coef_addr"}, int'(coef_addr), 0);
        check_eq({tag, "_x_addr"}, int'(x_addr), 0);
        check_eq({tag, "_y_addr"}, int'(y_addr), 0);
        check_eq({tag, "_y_data"}, int'(y_data), 0);
    endtask

    task automatic load_single_tap();
        coef_mem[0] = 16'h4000;
        x_mem[0] = 16'd100;
        x_mem[1] = 16'd200;
        x_mem[2] = 16'(-300);
        x_mem[3] = 16'h7FFF;
        exp_y[0] = 50;
        exp_y[1] = 100;
        exp_y[2] = -150;
        exp_y[3] = 16384;
    endtask

    int edges;

    initial begin
        for (int i = 0; i < 64; i++) coef_mem[i] = '0;
        for (int i = 0; i < 16384; i++) x_mem[i] = '0;
        rst        = 1'b1;
        Start      = 1'b0;
        Ile_wsp    = '0;
        Ile_probek = '0;
        repeat (3) @(posedge clk_b);
        @(negedge clk_b);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Single-tap gain of 0.5
        load_single_tap();
        run_fir(1, 4, 1'b0, edges);
        check_run("gain", edges, 15, 13, 4);

        // Three-tap average-style filter
        coef_mem[0] = 16'h4000;
        coef_mem[1] = 16'h4000;
        coef_mem[2] = 16'h4000;
        x_mem[0] = 16'd1000;
        x_mem[1] = 16'd2000;
        x_mem[2] = 16'd3000;
        x_mem[3] = 16'd4000;
        exp_y[0] = 500;
        exp_y[1] = 1500;
        exp_y[2] = 3000;
        exp_y[3] = 4500;
        run_fir(3, 4, 1'b0, edges);
        check_run("tap3", edges, 20, 18, 4);

        // (-1)*(-1) products saturate positive
        coef_mem[0] = 16'h8000;
        coef_mem[1] = 16'h8000;
        x_mem[0] = 16'h8000;
        x_mem[1] = 16'h8000;
        exp_y[0] = 32767;
        exp_y[1] = 32767;
        run_fir(2, 2, 1'b0, edges);
        check_run("sat", edges, 10, 8, 2);

        // Zero-parameter runs
        run_fir(1, 0, 1'b0, edges);
        check_run("n_zero", edges, 3, 1, 0);
        run_fir(0, 5, 1'b0, edges);
        check_run("w_zero", edges, 3, 1, 0);

        // Start edge and parameter changes while busy are ignored
        load_single_tap();
        run_fir(1, 4, 1'b1, edges);
        check_run("busy_start", edges, 15, 13, 4);

        // Fresh edge after DONE repeats the run
        run_fir(1, 4, 1'b0, edges);
        check_run("repeat", edges, 15, 13, 4);

        // Reset in the middle of MAC for output 1
        coef_mem[0] = 16'h4000;
        coef_mem[1] = 16'h4000;
        coef_mem[2] = 16'h4000;
        @(negedge clk_b);
        Ile_wsp    = 6'd3;
        Ile_probek = 14'd4;
        Start      = 1'b1;
        repeat (6) @(posedge clk_b);
        @(negedge clk_b);
        check_eq("pre_rst_busy", int'(pracuje), 1);
        rst   = 1'b1;
        Start = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(posedge clk_b);
        @(negedge clk_b);
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        repeat (40) @(posedge clk_b);
        @(negedge clk_b);
        check_eq("mid_rst_no_we", wr_addr.size(), 0);
        check_eq("mid_rst_idle", int'(pracuje), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
